// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port word memory between instruction fetch and load/store.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration instead of LS priority with a starvation guard.
module mem_arbiter #(
  parameter int IDX_W      = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        ls_req_valid,
  input  logic        ls_req_we,
  input  logic [31:0] ls_req_addr,
  input  logic [31:0] ls_req_wdata,
  output logic        ls_req_ready,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rsp_data,
  output logic        mem_write_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  // Handshake: a request transfers in any cycle where valid & ready are both high.
  // ready is a same-cycle function of valid, never high without valid, and at
  // most one port is ready per cycle. Responses are single-cycle pulses with no
  // backpressure.

  logic             if_gnt;
  logic             ls_gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] last_idx;
  logic             rsp_valid_q;
  logic             rsp_port_q;   // 0 = IF owns the response, 1 = LS
  logic             unused_addr_bits;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr;  // 0 = LS first on the next contended cycle

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst_n) begin
      if (if_req_valid && ls_req_valid) begin
        if_gnt = rr_ptr;
        ls_gnt = !rr_ptr;
      end else begin
        if_gnt = if_req_valid;
        ls_gnt = ls_req_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (if_req_valid && ls_req_valid) begin
      rr_ptr <= !rr_ptr;
    end
  end
`else
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (rst_n) begin
      if (if_req_valid && (!ls_req_valid || starve_cnt == STARVE_LIM)) begin
        if_gnt = 1'b1;
      end else if (ls_req_valid) begin
        ls_gnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_req_valid && !if_gnt) begin
      if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end
`endif

  assign gnt_idx = ls_gnt ? ls_req_addr[IDX_W+1:2] : if_req_addr[IDX_W+1:2];

  // Upper address bits wrap away and byte offsets are ignored by a word memory.
  assign unused_addr_bits = ^{if_req_addr[31:IDX_W+2], if_req_addr[1:0],
                              ls_req_addr[31:IDX_W+2], ls_req_addr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_port_q  <= 1'b0;
      last_idx    <= '0;
    end else begin
      rsp_valid_q <= if_gnt || (ls_gnt && !ls_req_we);
      rsp_port_q  <= ls_gnt;
      if (if_gnt || ls_gnt) last_idx <= gnt_idx;
    end
  end

  assign if_req_ready   = if_gnt;
  assign ls_req_ready   = ls_gnt;
  assign mem_write_en   = ls_gnt && ls_req_we;
  assign mem_addr       = {{(32-IDX_W){1'b0}}, ((if_gnt || ls_gnt) ? gnt_idx : last_idx)};
  assign mem_write_data = rst_n ? ls_req_wdata : 32'h0;

  assign if_rsp_valid = rsp_valid_q && !rsp_port_q;
  assign ls_rsp_valid = rsp_valid_q && rsp_port_q;
  assign if_rsp_data  = if_rsp_valid ? mem_read_data : 32'h0;
  assign ls_rsp_data  = ls_rsp_valid ? mem_read_data : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read word memory model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_req_ready;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid;
  logic        ls_req_we;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_req_ready;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int checks;
  int errors;
  logic [31:0] exp_q[$];
  logic [31:0] mem[4096];

  mem_arbiter #(.IDX_W(12), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_we(ls_req_we), .ls_req_addr(ls_req_addr),
    .ls_req_wdata(ls_req_wdata), .ls_req_ready(ls_req_ready),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Clock and memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[11:0]] <= mem_write_data;
    mem_read_data <= mem[mem_addr[11:0]];
  end

  // Driver tasks
  task automatic drive(input logic iv, input logic [31:0] ia, input logic lv,
                       input logic lwe, input logic [31:0] la, input logic [31:0] lwd);
    if_req_valid = iv;
    if_req_addr  = ia;
    ls_req_valid = lv;
    ls_req_we    = lwe;
    ls_req_addr  = la;
    ls_req_wdata = lwd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic exp_if;
  logic prev_if;

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | i;
    mem[4] = 32'hDEAD_BEEF;
    mem_read_data = 32'h0;

    // Reset with requests present: everything must stay quiet
    rst_n = 1'b0;
    drive(1'b1, 32'h10, 1'b1, 1'b1, 32'h20, 32'h55);
    #2;
    check("rst_if_ready", if_req_ready, 0);
    check("rst_ls_ready", ls_req_ready, 0);
    check("rst_we", mem_write_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_write_data, 0);
    check("rst_if_rsp", if_rsp_valid, 0);
    check("rst_ls_rsp", ls_rsp_valid, 0);
    repeat (2) @(posedge clk);
    #2;
    check("rst_held_we", mem_write_en, 0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;

    // 1: IF-only read of word 4
    next_cycle(); drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    check("t1_if_ready", if_req_ready, 1);
    check("t1_ls_ready", ls_req_ready, 0);
    check("t1_addr", mem_addr, 4);
    check("t1_we", mem_write_en, 0);
    next_cycle(); idle(); #1;
    check("t1_if_rsp", if_rsp_valid, 1);
    check("t1_if_data", if_rsp_data, 32'hDEAD_BEEF);
    check("t1_ls_rsp", ls_rsp_valid, 0);
    check("t1_ls_data", ls_rsp_data, 0);
    check("t1_addr_hold", mem_addr, 4);
    check("t1_if_ready_idle", if_req_ready, 0);

    // 2: LS write then read of the same word
    next_cycle(); drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h1234_5678); #1;
    check("t2_w_ready", ls_req_ready, 1);
    check("t2_we", mem_write_en, 1);
    check("t2_w_addr", mem_addr, 8);
    check("t2_wdata", mem_write_data, 32'h1234_5678);
    next_cycle(); drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0); #1;
    check("t2_r_ready", ls_req_ready, 1);
    check("t2_r_we", mem_write_en, 0);
    check("t2_no_wr_rsp", ls_rsp_valid, 0);
    next_cycle(); idle(); #1;
    check("t2_ls_rsp", ls_rsp_valid, 1);
    check("t2_ls_data", ls_rsp_data, 32'h1234_5678);
    check("t2_if_rsp", if_rsp_valid, 0);

    // 3: both ports valid every cycle
    prev_if = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle(); drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0); #1;
`ifdef MEM_ARB_RR_EN
      exp_if = (i % 2) == 1;
`else
      exp_if = (i % 5) == 4;
`endif
      check($sformatf("t3_if_ready_%0d", i), if_req_ready, exp_if);
      check($sformatf("t3_ls_ready_%0d", i), ls_req_ready, !exp_if);
      check($sformatf("t3_addr_%0d", i), mem_addr, exp_if ? 32'd0 : 32'd1);
      if (i > 0) begin
        check($sformatf("t3_if_rsp_%0d", i), if_rsp_valid, prev_if);
        check($sformatf("t3_ls_rsp_%0d", i), ls_rsp_valid, !prev_if);
        if (prev_if) check($sformatf("t3_if_data_%0d", i), if_rsp_data, 32'hA000_0000);
        else         check($sformatf("t3_ls_data_%0d", i), ls_rsp_data, 32'hA000_0001);
      end
      prev_if = exp_if;
    end
    next_cycle(); idle(); #1;

    // 4: back-to-back IF reads, responses matched against an expected queue
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      if (k < 3) drive(1'b1, 32'(k * 4), 1'b0, 1'b0, 32'h0, 32'h0);
      else       idle();
      #1;
      if (k < 3) begin
        check($sformatf("t4_ready_%0d", k), if_req_ready, 1);
        exp_q.push_back(32'hA000_0000 | 32'(k));
      end
      if (k > 0) begin
        check($sformatf("t4_rsp_%0d", k), if_rsp_valid, 1);
        if (if_rsp_valid && exp_q.size() > 0)
          check($sformatf("t4_data_%0d", k), if_rsp_data, exp_q.pop_front());
      end
    end
    check("t4_q_empty", exp_q.size(), 0);

    // 5: reset while a read response is pending
    next_cycle(); drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    check("t5_ready", if_req_ready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", if_req_ready, 0);
    check("t5_rst_addr", mem_addr, 0);
    next_cycle(); #1;
    check("t5_rst_if_rsp", if_rsp_valid, 0);
    check("t5_rst_ls_rsp", ls_rsp_valid, 0);
    check("t5_rst_data", if_rsp_data, 0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    next_cycle(); #1;
    check("t5_post_if_rsp", if_rsp_valid, 0);
    check("t5_post_ls_rsp", ls_rsp_valid, 0);
    next_cycle(); drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    check("t5_rd_ready", if_req_ready, 1);
    next_cycle(); idle(); #1;
    check("t5_rd_rsp", if_rsp_valid, 1);
    check("t5_rd_data", if_rsp_data, 32'hA000_0002);

    // 6: LS read past the top of memory wraps
    next_cycle(); drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_4004, 32'h0); #1;
    check("t6_addr", mem_addr, 1);
    next_cycle(); idle(); #1;
    check("t6_rsp", ls_rsp_valid, 1);
    check("t6_data", ls_rsp_data, 32'hA000_0001);

    // 7: IF read collides with LS write to the same word; IF retries and sees new data
    next_cycle(); drive(1'b1, 32'h30, 1'b1, 1'b1, 32'h30, 32'hCAFE_F00D); #1;
    check("t7_ls_ready", ls_req_ready, 1);
    check("t7_if_ready", if_req_ready, 0);
    check("t7_we", mem_write_en, 1);
    next_cycle(); drive(1'b1, 32'h30, 1'b0, 1'b0, 32'h0, 32'h0); #1;
    check("t7_retry_ready", if_req_ready, 1);
    check("t7_retry_addr", mem_addr, 12);
    next_cycle(); idle(); #1;
    check("t7_rsp", if_rsp_valid, 1);
    check("t7_data", if_rsp_data, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
